// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the MIPS instruction-fetch stage and its IF/ID register.
package fetch_stage_pkg;

   localparam logic [31:0] NOP_INSTR_WORD   = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_INC           = 32'd4;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_plus4;
      logic        valid;
   } ifid_t;

   // Redirect targets are word addresses; the low two bits are dropped on load.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush beats write-enable, which beats hold.
module ifid_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  write_en,
   input  logic  flush,
   input  ifid_t ifid_in,
   output ifid_t ifid_out
);

   ifid_t ifid_q;
   ifid_t ifid_d;
   ifid_t ifid_bubble;

   always_comb begin
      ifid_bubble          = '0;
      ifid_bubble.instr    = NOP_INSTR;
      ifid_bubble.pc_plus4 = 32'h0000_0000;
      ifid_bubble.valid    = 1'b0;
   end

   always_comb begin
      ifid_d = ifid_q;
      if (flush) begin
         ifid_d = ifid_bubble;
      end else if (write_en) begin
         ifid_d = ifid_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ifid_q <= ifid_bubble;
      end else begin
         ifid_q <= ifid_d;
      end
   end

   assign ifid_out = ifid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection, IF/ID register and performance counters.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD,
   parameter int          CNT_WIDTH = 32
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 PCWrite,
   input  logic                 IFIDWrite,
   input  logic                 PCSrc,
   input  logic [31:0]          BranchTarget,
   input  logic                 IFIDFlush,
   input  logic [31:0]          InstrMemData,
   output logic [31:0]          InstrMemAddr,
   output logic [31:0]          IFID_Instruction,
   output logic [31:0]          IFID_PCPlus4,
   output logic                 IFID_Valid,
   output logic [CNT_WIDTH-1:0] FetchCount,
   output logic [CNT_WIDTH-1:0] StallCount
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   logic [31:0]          pc_q;
   logic [31:0]          pc_d;
   logic [31:0]          pc_plus4;
   logic [CNT_WIDTH-1:0] fetch_cnt_q;
   logic [CNT_WIDTH-1:0] fetch_cnt_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q;
   logic [CNT_WIDTH-1:0] stall_cnt_d;
   logic                 ifid_flush;
   logic                 ifid_load;
   logic                 ifid_stall;
   ifid_t                ifid_next;
   ifid_t                ifid_cur;

   assign pc_plus4 = pc_q + PC_INC;

   // A taken redirect overrides a PC stall: the stalled younger instruction is dead anyway.
   always_comb begin
      pc_d = pc_q;
      if (PCSrc) begin
         pc_d = align_word(BranchTarget);
      end else if (PCWrite) begin
         pc_d = pc_plus4;
      end
   end

   always_comb begin
      ifid_flush = IFIDFlush | PCSrc;
      ifid_load  = IFIDWrite & ~ifid_flush;
      ifid_stall = ~IFIDWrite & ~ifid_flush;
   end

   always_comb begin
      ifid_next          = '0;
      ifid_next.instr    = InstrMemData;
      ifid_next.pc_plus4 = pc_plus4;
      ifid_next.valid    = 1'b1;
   end

   ifid_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_ifid_reg (
      .clk      (Clk),
      .reset    (Reset),
      .write_en (IFIDWrite),
      .flush    (ifid_flush),
      .ifid_in  (ifid_next),
      .ifid_out (ifid_cur)
   );

   // Both counters stick at all-ones so a long lab run never reads back as small.
   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (ifid_load && (fetch_cnt_q != CNT_MAX)) begin
         fetch_cnt_d = fetch_cnt_q + CNT_ONE;
      end
      if (ifid_stall && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         pc_q        <= RESET_PC;
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         pc_q        <= pc_d;
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign InstrMemAddr     = pc_q;
   assign IFID_Instruction = ifid_cur.instr;
   assign IFID_PCPlus4     = ifid_cur.pc_plus4;
   assign IFID_Valid       = ifid_cur.valid;
   assign FetchCount       = fetch_cnt_q;
   assign StallCount       = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; memory returns its address as data.
module tb_fetch_stage;

   logic        Clk;
   logic        Reset;
   logic        PCWrite;
   logic        IFIDWrite;
   logic        PCSrc;
   logic [31:0] BranchTarget;
   logic        IFIDFlush;
   logic [31:0] InstrMemData;
   logic [31:0] InstrMemAddr;
   logic [31:0] IFID_Instruction;
   logic [31:0] IFID_PCPlus4;
   logic        IFID_Valid;
   logic [31:0] FetchCount;
   logic [31:0] StallCount;

   logic [31:0] smallInstrMemAddr;
   logic [31:0] smallInstruction;
   logic [31:0] smallPCPlus4;
   logic        smallValid;
   logic [1:0]  smallFetchCount;
   logic [1:0]  smallStallCount;

   int vectors;
   int miscompares;

   fetch_stage dut (
      .Clk              (Clk),
      .Reset            (Reset),
      .PCWrite          (PCWrite),
      .IFIDWrite        (IFIDWrite),
      .PCSrc            (PCSrc),
      .BranchTarget     (BranchTarget),
      .IFIDFlush        (IFIDFlush),
      .InstrMemData     (InstrMemData),
      .InstrMemAddr     (InstrMemAddr),
      .IFID_Instruction (IFID_Instruction),
      .IFID_PCPlus4     (IFID_PCPlus4),
      .IFID_Valid       (IFID_Valid),
      .FetchCount       (FetchCount),
      .StallCount       (StallCount)
   );

   fetch_stage #(.CNT_WIDTH(2)) dutSmall (
      .Clk              (Clk),
      .Reset            (Reset),
      .PCWrite          (PCWrite),
      .IFIDWrite        (IFIDWrite),
      .PCSrc            (PCSrc),
      .BranchTarget     (BranchTarget),
      .IFIDFlush        (IFIDFlush),
      .InstrMemData     (InstrMemData),
      .InstrMemAddr     (smallInstrMemAddr),
      .IFID_Instruction (smallInstruction),
      .IFID_PCPlus4     (smallPCPlus4),
      .IFID_Valid       (smallValid),
      .FetchCount       (smallFetchCount),
      .StallCount       (smallStallCount)
   );

   // Zero-latency instruction memory whose contents equal the address.
   assign InstrMemData = InstrMemAddr;

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic applyStimulus(input logic rst, input logic pcw, input logic ifw,
                                input logic src, input logic [31:0] tgt, input logic fl);
      Reset        = rst;
      PCWrite      = pcw;
      IFIDWrite    = ifw;
      PCSrc        = src;
      BranchTarget = tgt;
      IFIDFlush    = fl;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkState(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                             input logic [31:0] pcp4, input logic vld,
                             input logic [31:0] fcnt, input logic [31:0] scnt);
      checkOutput({tag, ".pc"}, InstrMemAddr, pc);
      checkOutput({tag, ".instr"}, IFID_Instruction, instr);
      checkOutput({tag, ".pcplus4"}, IFID_PCPlus4, pcp4);
      checkOutput({tag, ".valid"}, {31'd0, IFID_Valid}, {31'd0, vld});
      checkOutput({tag, ".fetchcnt"}, FetchCount, fcnt);
      checkOutput({tag, ".stallcnt"}, StallCount, scnt);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;

      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      tick();
      checkState("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 32'd0);

      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("release.addr_comb", InstrMemAddr, 32'h0);
      checkOutput("release.valid_still0", {31'd0, IFID_Valid}, 32'd0);
      tick();
      checkState("fetch1", 32'h4, 32'h0, 32'h4, 1'b1, 32'd1, 32'd0);
      tick();
      checkState("fetch2", 32'h8, 32'h4, 32'h8, 1'b1, 32'd2, 32'd0);

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      checkState("stall1", 32'h8, 32'h4, 32'h8, 1'b1, 32'd2, 32'd1);
      tick();
      checkState("stall2", 32'h8, 32'h4, 32'h8, 1'b1, 32'd2, 32'd2);

      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      checkState("resume1", 32'hC, 32'h8, 32'hC, 1'b1, 32'd3, 32'd2);
      tick();
      checkState("resume2", 32'h10, 32'hC, 32'h10, 1'b1, 32'd4, 32'd2);
      checkOutput("small.fetch_sat3", {30'd0, smallFetchCount}, 32'd3);

      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b0);
      tick();
      checkState("redirect", 32'h40, 32'h0, 32'h0, 1'b0, 32'd4, 32'd2);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      checkState("after_redirect", 32'h44, 32'h40, 32'h44, 1'b1, 32'd5, 32'd2);

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0);
      tick();
      checkState("stall_and_redirect", 32'h80, 32'h0, 32'h0, 1'b0, 32'd5, 32'd2);

      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      checkState("flush_beats_stall", 32'h84, 32'h0, 32'h0, 1'b0, 32'd5, 32'd2);

      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      checkState("pchold_ifidload", 32'h84, 32'h84, 32'h88, 1'b1, 32'd6, 32'd2);
      tick();
      checkState("pchold_ifidreload", 32'h84, 32'h84, 32'h88, 1'b1, 32'd7, 32'd2);

      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
      tick();
      checkState("to_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd7, 32'd2);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      checkState("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'd8, 32'd2);

      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h43, 1'b0);
      tick();
      checkOutput("align.pc", InstrMemAddr, 32'h40);

      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 1'b0);
      tick();
      checkOutput("goto20.pc", InstrMemAddr, 32'h20);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick();
      checkState("pre_reset_stall", 32'h20, 32'h0, 32'h0, 1'b0, 32'd8, 32'd3);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0);
      tick();
      checkState("reset_mid_stall", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0, 32'd0);

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
      end
      checkOutput("stall4.big", StallCount, 32'd4);
      checkOutput("stall4.small_sat", {30'd0, smallStallCount}, 32'd3);
      checkOutput("stall4.pc", InstrMemAddr, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline. It drives the PC to instruction memory and obeys the hazard unit's PCWrite/IFIDWrite stall controls. It accepts branch/jump redirects and flushes from later stages, and hands Instruction/PCPlus4/valid to the decode stage. It also keeps fetch and stall counters for the lab performance readout.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, instruction word injected into IF/ID on flush/reset (sll $0,$0,0).
CNT_WIDTH, 32, width of FetchCount and StallCount counters.

Ports:
Clk  input  1  pipeline clock, all state updates on posedge.
Reset  input  1  synchronous, active-high reset.
PCWrite  input  1  from hazard unit; 0 holds PC.
IFIDWrite  input  1  from hazard unit; 0 holds IF/ID register.
PCSrc  input  1  1 = redirect PC to BranchTarget this cycle (taken branch/jump, resolved downstream).
BranchTarget  input  32  redirect address, word aligned.
IFIDFlush  input  1  1 = replace IF/ID contents with NOP_INSTR next edge.
InstrMemData  input  32  instruction word at InstrMemAddr (combinational memory).
InstrMemAddr  output  32  current PC.
IFID_Instruction  output  32  registered instruction to decode.
IFID_PCPlus4  output  32  registered PC+4 of that instruction.
IFID_Valid  output  1  1 = IF/ID holds a real fetched instruction.
FetchCount  output  CNT_WIDTH  instructions latched valid into IF/ID.
StallCount  output  CNT_WIDTH  cycles IF/ID held by IFIDWrite=0.

Behaviour:
- Reset (sync, wins over all): PC=RESET_PC, IFID_Instruction=NOP_INSTR, IFID_PCPlus4=0, IFID_Valid=0, FetchCount=0, StallCount=0. Reset asserted mid-stall or mid-redirect discards all pending state.
- PC next-state priority (non-reset): PCSrc=1 -> BranchTarget (overrides PCWrite=0; a resolved branch kills the stalled younger instruction); else PCWrite=1 -> PC+4; else hold.
- PC arithmetic: 32-bit modulo; PC 32'hFFFF_FFFC + 4 wraps to 0. BranchTarget[1:0] are forced to 00 on load.
- InstrMemAddr = PC combinationally; zero-cycle memory read; fetch latency PC->IF/ID is one edge.
- IF/ID next-state priority: IFIDFlush=1 or PCSrc=1 -> Instruction=NOP_INSTR, PCPlus4=0, Valid=0 (flush beats stall); else IFIDWrite=1 -> Instruction=InstrMemData, PCPlus4=PC+4, Valid=1; else hold all three.
- Hazard-unit startup: PCWrite/IFIDWrite are treated as valid from the first post-reset cycle; no internal warm-up gating.
- PCWrite=0 with IFIDWrite=1 (unsupported by hazard unit) : PC holds, IF/ID reloads same instruction; legal, not flagged.
- FetchCount increments on every edge where IF/ID loads with Valid=1 (not flush). StallCount increments on every edge where IFIDWrite=0 and no flush/PCSrc. Both saturate at all-ones, never wrap.
- Outputs change only on posedge Clk except InstrMemAddr (follows PC register).

Decomposition:
- Shared package: NOP_INSTR constant, RESET_PC default, PC_INC=4.
- One sub-module: ifid_reg (Instruction/PCPlus4/Valid register with write-enable and flush, flush priority). PC register, next-PC mux and counters stay in fetch_stage.

Test Plan:
- Reset held 2 cycles then released, memory returns addr-as-data -> InstrMemAddr 0,4,8; IFID_PCPlus4 4,8,12; Valid=0 until first edge after release, then 1.
- Hazard stall: PCWrite=IFIDWrite=0 for 2 cycles at PC=8 -> PC stays 8, IF/ID holds PCPlus4=8, StallCount=2, FetchCount does not increment.
- Redirect: PCSrc=1, BranchTarget=0x40 at PC=0x10 -> next PC=0x40, IF/ID=NOP, Valid=0; following edge IFID_PCPlus4=0x44.
- Simultaneous stall and redirect: PCWrite=IFIDWrite=0, PCSrc=1, target 0x80 -> PC=0x80, IF/ID flushed, StallCount unchanged.
- Wrap and alignment: PC=0xFFFF_FFFC, run one cycle -> PC=0; BranchTarget=0x43 -> PC=0x40.
- Reset mid-stall: Reset asserted while PCWrite=0 at PC=0x20 -> next edge PC=RESET_PC, counters 0, Valid=0.
